// File: rtl/bcd_draw_pkg.sv
// Shared types, constants and seven-segment helper for the BCD digit drawer.
package bcd_draw_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } flash_state_t;

    typedef struct packed {
        bcd_t hundreds;
        bcd_t tens;
        bcd_t ones;
    } bcd_value_t;

    localparam int unsigned GLYPH_W     = 8;
    localparam int unsigned GLYPH_H     = 16;
    localparam int unsigned NUM_DIGITS  = 3;
    localparam int unsigned BOX_W       = GLYPH_W * NUM_DIGITS;
    localparam logic [7:0]  TRANSPARENT = 8'h00;

    // Segment set {a,b,c,d,e,f,g} for a BCD digit; invalid codes light nothing.
    function automatic logic [6:0] bcd_segments(input bcd_t d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b111_1110;
            4'd1:    seg = 7'b011_0000;
            4'd2:    seg = 7'b110_1101;
            4'd3:    seg = 7'b111_1001;
            4'd4:    seg = 7'b011_0011;
            4'd5:    seg = 7'b101_1011;
            4'd6:    seg = 7'b101_1111;
            4'd7:    seg = 7'b111_0000;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b111_1011;
            default: seg = 7'b000_0000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digits_drawer_number_bitmap.sv
// 8x16 font ROM for BCD digits built from seven-segment strokes; digits above 9 are blank.
module number_bitmap
    import bcd_draw_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] row,
    input  logic [2:0] col,
    output logic       lit
);

    localparam logic [7:0] BAR   = 8'b0111_1110;
    localparam logic [7:0] LEFT  = 8'b0100_0000;
    localparam logic [7:0] RIGHT = 8'b0000_0010;

    logic [6:0] seg;
    logic [7:0] row_bits;

    // Rows 2/8/13 carry horizontal bars, 3-7 and 9-12 the vertical strokes.
    always_comb begin
        seg      = bcd_segments(bcd_t'(digit));
        row_bits = 8'h00;
        if (row == 4'd2) begin
            row_bits = {8{seg[6]}} & BAR;
        end else if (row inside {[4'd3:4'd7]}) begin
            row_bits = ({8{seg[1]}} & LEFT) | ({8{seg[5]}} & RIGHT);
        end else if (row == 4'd8) begin
            row_bits = {8{seg[0]}} & BAR;
        end else if (row inside {[4'd9:4'd12]}) begin
            row_bits = ({8{seg[2]}} & LEFT) | ({8{seg[4]}} & RIGHT);
        end else if (row == 4'd13) begin
            row_bits = {8{seg[3]}} & BAR;
        end
        lit = row_bits[3'd7 - col];
    end

endmodule

// File: rtl/bcd_digits_drawer.sv
// Draws a three-digit BCD value as 8x16 glyphs with per-frame snapshot and change-flash.
// Build option: LEADING_ZERO_BLANK_EN suppresses leading zero hundreds/tens glyphs.
module bcd_digits_drawer
    import bcd_draw_pkg::*;
#(
    parameter logic [10:0] TOP_LEFT_X   = 11'd16,
    parameter logic [10:0] TOP_LEFT_Y   = 11'd8,
    parameter logic [7:0]  DIGIT_COLOR  = 8'hFF,
    parameter logic [7:0]  FLASH_COLOR  = 8'hE0,
    parameter logic [5:0]  FLASH_FRAMES = 6'd32,
    parameter logic [2:0]  FLASH_HALF   = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [3:0]  onesIn,
    input  logic [3:0]  tensIn,
    input  logic [3:0]  hundredsIn,
    output logic        drawingRequest,
    output logic [7:0]  RGBout
);

    bcd_value_t   snap_q, snap_d, in_value;
    flash_state_t state_q, state_d;
    logic [5:0]   frame_cnt_q, frame_cnt_d;
    logic [2:0]   half_cnt_q, half_cnt_d;
    logic         draw_q, draw_d;
    logic [7:0]   rgb_q, rgb_d;

    logic [10:0]  off_x, off_y;
    logic         in_box;
    logic [1:0]   glyph_idx;
    bcd_t         glyph_digit;
    logic         glyph_lit;
    logic         lead_blank;

    assign in_value = '{hundreds: bcd_t'(hundredsIn), tens: bcd_t'(tensIn), ones: bcd_t'(onesIn)};

    // Box geometry; unsigned wrap makes pixels left/above the box fail the range test.
    assign off_x     = pixelX - TOP_LEFT_X;
    assign off_y     = pixelY - TOP_LEFT_Y;
    assign in_box    = (off_x < 11'(BOX_W)) && (off_y < 11'(GLYPH_H));
    assign glyph_idx = off_x[4:3];

    always_comb begin
        case (glyph_idx)
            2'd0:    glyph_digit = snap_q.hundreds;
            2'd1:    glyph_digit = snap_q.tens;
            2'd2:    glyph_digit = snap_q.ones;
            default: glyph_digit = 4'hF;
        endcase
    end

    number_bitmap u_bitmap (
        .digit (glyph_digit),
        .row   (off_y[3:0]),
        .col   (off_x[2:0]),
        .lit   (glyph_lit)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign lead_blank = ((glyph_idx == 2'd0) && (snap_q.hundreds == 4'd0)) ||
                        ((glyph_idx == 2'd1) && (snap_q.hundreds == 4'd0) && (snap_q.tens == 4'd0));
`else
    assign lead_blank = 1'b0;
`endif

    // Snapshot and flash sequencing; everything advances only at frame start.
    always_comb begin
        snap_d      = snap_q;
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        half_cnt_d  = half_cnt_q;
        if (startOfFrame) begin
            snap_d = in_value;
            if ((in_value != snap_q) && (FLASH_FRAMES != 6'd0)) begin
                state_d     = FLASH_ON;
                frame_cnt_d = FLASH_FRAMES;
                half_cnt_d  = FLASH_HALF;
            end else if (state_q != IDLE) begin
                frame_cnt_d = frame_cnt_q - 6'd1;
                half_cnt_d  = half_cnt_q - 3'd1;
                if (frame_cnt_d == 6'd0) begin
                    state_d = IDLE;
                end else if (half_cnt_d == 3'd0) begin
                    state_d    = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                    half_cnt_d = FLASH_HALF;
                end
            end
        end
    end

    // Pixel decision uses the pre-update snapshot and state of this cycle.
    always_comb begin
        draw_d = in_box && glyph_lit && !lead_blank && (state_q != FLASH_OFF);
        rgb_d  = TRANSPARENT;
        if (draw_d) begin
            rgb_d = (state_q == FLASH_ON) ? FLASH_COLOR : DIGIT_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q      <= '0;
            state_q     <= IDLE;
            frame_cnt_q <= 6'd0;
            half_cnt_q  <= 3'd0;
            draw_q      <= 1'b0;
            rgb_q       <= TRANSPARENT;
        end else begin
            snap_q      <= snap_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            half_cnt_q  <= half_cnt_d;
            draw_q      <= draw_d;
            rgb_q       <= rgb_d;
        end
    end

    assign drawingRequest = draw_q;
    assign RGBout         = rgb_q;

endmodule

// File: tb/tb_bcd_digits_drawer.sv
// Directed self-checking bench for bcd_digits_drawer with hand-derived glyph row patterns.
module tb_bcd_digits_drawer;

    localparam logic [10:0] TLX = 11'd16;
    localparam logic [10:0] TLY = 11'd8;
    localparam logic [7:0]  DIG = 8'hFF;
    localparam logic [7:0]  FLC = 8'hE0;

    logic        clk = 1'b0;
    logic        reset;
    logic        sof;
    logic [10:0] px, py;
    logic [3:0]  ones, tens, hund;
    logic        dr;
    logic [7:0]  rgb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_digits_drawer dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (sof),
        .pixelX         (px),
        .pixelY         (py),
        .onesIn         (ones),
        .tensIn         (tens),
        .hundredsIn     (hund),
        .drawingRequest (dr),
        .RGBout         (rgb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        step();
        sof = 1'b0;
    endtask

    // Scans one line across the box plus one pixel either side; bit 23 is the hundreds column 0.
    task automatic scan_row(input logic [10:0] y, input logic [7:0] col_exp,
                            output logic [23:0] mask, output logic col_ok, output logic edge_dr);
        mask    = '0;
        col_ok  = 1'b1;
        py      = y;
        px      = TLX - 11'd1;
        step();
        edge_dr = dr;
        for (int i = 0; i < 24; i++) begin
            px = TLX + 11'(i);
            step();
            mask[23-i] = dr;
            if (dr && rgb !== col_exp) col_ok = 1'b0;
            if (!dr && rgb !== 8'h00) col_ok = 1'b0;
        end
        px = TLX + 11'd24;
        step();
        edge_dr = edge_dr | dr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        px = TLX + 11'd1;
        py = TLY + 11'd2;
        step();
        step();
        checks++;
        if (dr !== 1'b0) begin errors++; $display("FAIL reset_dr: got %0b want 0", dr); end
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %02h want 00", rgb); end
        reset = 1'b0;
        step();
        checks++;
        if (dr !== 1'b1 || rgb !== DIG) begin
            errors++; $display("FAIL post_reset_000: got dr=%0b rgb=%02h want dr=1 rgb=%02h", dr, rgb, DIG);
        end
    endtask

    task automatic test_first_frame();
        logic [10:0] ys[5]   = '{TLY + 11'd2, TLY + 11'd5, TLY + 11'd8, TLY + 11'd10, TLY + 11'd18};
        logic [23:0] exps[5] = '{24'h007E7E, 24'h024242, 24'h000000, 24'h024242, 24'h000000};
        logic [23:0] mask;
        logic        cok, edg;
        hund = 4'd1; tens = 4'd0; ones = 4'd0;
        pulse_sof();
        px = TLX + 11'd6; py = TLY + 11'd5;
        step();
        checks++;
        if (dr !== 1'b1 || rgb !== FLC) begin
            errors++; $display("FAIL first_change_flash: got dr=%0b rgb=%02h want dr=1 rgb=%02h", dr, rgb, FLC);
        end
        for (int f = 0; f < 32; f++) pulse_sof();
        for (int i = 0; i < 5; i++) begin
            scan_row(ys[i], DIG, mask, cok, edg);
            checks++;
            if (mask !== exps[i] || !cok || edg) begin
                errors++;
                $display("FAIL scan_100 y=%0d: got mask=%06h colour_ok=%0b edge=%0b want mask=%06h colour_ok=1 edge=0",
                         ys[i], mask, cok, edg, exps[i]);
            end
        end
        px = TLX + 11'd6; py = TLY + 11'd5;
        step();
        checks++;
        if (dr !== 1'b1) begin errors++; $display("FAIL latency_lit: got %0b want 1", dr); end
        px = TLX;
        #1;
        checks++;
        if (dr !== 1'b1) begin errors++; $display("FAIL latency_hold: got %0b want 1", dr); end
        step();
        checks++;
        if (dr !== 1'b0 || rgb !== 8'h00) begin
            errors++; $display("FAIL latency_unlit: got dr=%0b rgb=%02h want dr=0 rgb=00", dr, rgb);
        end
    endtask

    task automatic test_flash();
        logic        on;
        logic [7:0]  want;
        logic [23:0] mask;
        logic        cok, edg;
        hund = 4'd0; tens = 4'd9; ones = 4'd9;
        pulse_sof();
        px = TLX + 11'd1; py = TLY + 11'd2;
        for (int f = 1; f <= 33; f++) begin
            step();
            on   = (f > 32) || ((((f - 1) / 4) % 2) == 0);
            want = (f > 32) ? DIG : (on ? FLC : 8'h00);
            checks++;
            if (dr !== on || rgb !== want) begin
                errors++;
                $display("FAIL flash_frame_%0d: got dr=%0b rgb=%02h want dr=%0b rgb=%02h", f, dr, rgb, on, want);
            end
            if (f < 33) pulse_sof();
        end
        scan_row(TLY + 11'd8, DIG, mask, cok, edg);
        checks++;
        if (mask !== 24'h007E7E || !cok || edg) begin
            errors++; $display("FAIL scan_099_row8: got mask=%06h colour_ok=%0b want 007e7e", mask, cok);
        end
        scan_row(TLY + 11'd10, DIG, mask, cok, edg);
        checks++;
        if (mask !== 24'h420202 || !cok || edg) begin
            errors++; $display("FAIL scan_099_row10: got mask=%06h colour_ok=%0b want 420202", mask, cok);
        end
    endtask

    task automatic test_midframe();
        logic [23:0] mask;
        logic        cok, edg;
        hund = 4'd1; tens = 4'd0; ones = 4'd0;
        scan_row(TLY + 11'd10, DIG, mask, cok, edg);
        checks++;
        if (mask !== 24'h420202 || !cok || edg) begin
            errors++; $display("FAIL midframe_hold: got mask=%06h colour_ok=%0b want 420202", mask, cok);
        end
        px = TLX + 11'd1; py = TLY + 11'd10;
        sof = 1'b1;
        step();
        sof = 1'b0;
        checks++;
        if (dr !== 1'b1 || rgb !== DIG) begin
            errors++; $display("FAIL sof_pixel_old: got dr=%0b rgb=%02h want dr=1 rgb=%02h", dr, rgb, DIG);
        end
        step();
        checks++;
        if (dr !== 1'b0 || rgb !== 8'h00) begin
            errors++; $display("FAIL sof_pixel_new: got dr=%0b rgb=%02h want dr=0 rgb=00", dr, rgb);
        end
        scan_row(TLY + 11'd10, FLC, mask, cok, edg);
        checks++;
        if (mask !== 24'h024242 || !cok || edg) begin
            errors++; $display("FAIL new_value_row10: got mask=%06h colour_ok=%0b want 024242", mask, cok);
        end
    endtask

    task automatic test_invalid_bcd();
        logic [23:0] mask;
        logic        cok, edg;
        for (int f = 0; f < 4; f++) pulse_sof();
        px = TLX + 11'd6; py = TLY + 11'd5;
        step();
        checks++;
        if (dr !== 1'b0 || rgb !== 8'h00) begin
            errors++; $display("FAIL flash_off_blank: got dr=%0b rgb=%02h want dr=0 rgb=00", dr, rgb);
        end
        hund = 4'd1; tens = 4'hA; ones = 4'd0;
        pulse_sof();
        step();
        checks++;
        if (dr !== 1'b1 || rgb !== FLC) begin
            errors++; $display("FAIL restart_on: got dr=%0b rgb=%02h want dr=1 rgb=%02h", dr, rgb, FLC);
        end
        scan_row(TLY + 11'd2, FLC, mask, cok, edg);
        checks++;
        if (mask !== 24'h00007E || !cok || edg) begin
            errors++; $display("FAIL invalid_tens_row2: got mask=%06h colour_ok=%0b want 00007e", mask, cok);
        end
        scan_row(TLY + 11'd10, FLC, mask, cok, edg);
        checks++;
        if (mask !== 24'h020042 || !cok || edg) begin
            errors++; $display("FAIL invalid_tens_row10: got mask=%06h colour_ok=%0b want 020042", mask, cok);
        end
        for (int f = 0; f < 3; f++) pulse_sof();
        px = TLX + 11'd6; py = TLY + 11'd5;
        step();
        checks++;
        if (dr !== 1'b1 || rgb !== FLC) begin
            errors++; $display("FAIL restart_full_half: got dr=%0b rgb=%02h want dr=1 rgb=%02h", dr, rgb, FLC);
        end
        pulse_sof();
        step();
        checks++;
        if (dr !== 1'b0) begin errors++; $display("FAIL restart_then_off: got %0b want 0", dr); end
    endtask

    task automatic test_leading_zero();
        logic [23:0] mask;
        logic        cok, edg;
        logic [23:0] exp2, exp10;
`ifdef LEADING_ZERO_BLANK_EN
        exp2  = 24'h00007E;
        exp10 = 24'h000002;
`else
        exp2  = 24'h7E7E7E;
        exp10 = 24'h424202;
`endif
        hund = 4'd0; tens = 4'd0; ones = 4'd7;
        pulse_sof();
        scan_row(TLY + 11'd2, FLC, mask, cok, edg);
        checks++;
        if (mask !== exp2 || !cok || edg) begin
            errors++; $display("FAIL value_007_row2: got mask=%06h colour_ok=%0b want %06h", mask, cok, exp2);
        end
        scan_row(TLY + 11'd10, FLC, mask, cok, edg);
        checks++;
        if (mask !== exp10 || !cok || edg) begin
            errors++; $display("FAIL value_007_row10: got mask=%06h colour_ok=%0b want %06h", mask, cok, exp10);
        end
    endtask

    task automatic test_reset_flash_off();
        for (int f = 0; f < 4; f++) pulse_sof();
        px = TLX + 11'd17; py = TLY + 11'd2;
        step();
        checks++;
        if (dr !== 1'b0) begin errors++; $display("FAIL pre_reset_off: got %0b want 0", dr); end
        px = TLX + 11'd17; py = TLY + 11'd10;
        reset = 1'b1;
        step();
        checks++;
        if (dr !== 1'b0 || rgb !== 8'h00) begin
            errors++; $display("FAIL midframe_reset: got dr=%0b rgb=%02h want dr=0 rgb=00", dr, rgb);
        end
        reset = 1'b0;
        step();
        checks++;
        if (dr !== 1'b1 || rgb !== DIG) begin
            errors++; $display("FAIL reset_snapshot_000: got dr=%0b rgb=%02h want dr=1 rgb=%02h", dr, rgb, DIG);
        end
        hund = 4'd0; tens = 4'd0; ones = 4'd0;
        pulse_sof();
        step();
        checks++;
        if (dr !== 1'b1 || rgb !== DIG) begin
            errors++; $display("FAIL reset_no_flash: got dr=%0b rgb=%02h want dr=1 rgb=%02h", dr, rgb, DIG);
        end
    endtask

    initial begin
        reset = 1'b1;
        sof   = 1'b0;
        px    = '0;
        py    = '0;
        ones  = '0;
        tens  = '0;
        hund  = '0;
        test_reset();
        test_first_frame();
        test_flash();
        test_midframe();
        test_invalid_bcd();
        test_leading_zero();
        test_reset_flash_off();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
